// File: rtl/exec_pkg.sv
// Shared execution-stage definitions: one-hot opcodes, issue FSM encoding,
// register index width and a register-index-to-mask helper.
// No ports; imported by exec_issue_ctrl, reg_scoreboard and the Execution stage.
package exec_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 1 << REG_IDX_W;

  // One-hot opcode encoding as presented by decode.
  localparam logic [15:0] OP_ADD  = 16'h0001;
  localparam logic [15:0] OP_SUB  = 16'h0002;
  localparam logic [15:0] OP_LI   = 16'h0004;
  localparam logic [15:0] OP_SHL  = 16'h0008;
  localparam logic [15:0] OP_SHR  = 16'h0010;
  localparam logic [15:0] OP_AND  = 16'h0020;
  localparam logic [15:0] OP_OR   = 16'h0040;
  localparam logic [15:0] OP_XOR  = 16'h0080;
  localparam logic [15:0] OP_BR   = 16'h0100;
  localparam logic [15:0] OP_BNE  = 16'h0200;
  localparam logic [15:0] OP_MOVE = 16'h0400;
  localparam logic [15:0] OP_ADDI = 16'h0800;
  localparam logic [15:0] OP_MUL  = 16'h1000;
  localparam logic [15:0] OP_HALT = 16'h2000;
  localparam logic [15:0] OP_NOP  = 16'h4000;

  // Ops that write id_rd, and ops that never read their source registers.
  localparam logic [15:0] OP_WR_MASK = OP_ADD | OP_SUB | OP_LI | OP_SHL | OP_SHR | OP_AND |
                                       OP_OR | OP_XOR | OP_MOVE | OP_ADDI | OP_MUL;
  localparam logic [15:0] OP_NO_SRC_MASK = OP_LI | OP_BR | OP_HALT | OP_NOP;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_BR_WAIT = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_HALTED  = 3'd4
  } issue_state_e;

  function automatic logic [NUM_REGS-1:0] idx_mask(input logic [REG_IDX_W-1:0] idx);
    idx_mask      = '0;
    idx_mask[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/exec_issue_ctrl_reg_scoreboard.sv
// Register pending scoreboard: one bit per architectural register, set when a writer issues.
// Ports: set_en_i/set_idx_i mark a register pending, clr_en_i/clr_idx_i retire it, pending_o is the state.
// Set wins over clear on the same register in the same cycle (the new writer is still in flight).
module reg_scoreboard
  import exec_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 set_en_i,
  input  logic [REG_IDX_W-1:0] set_idx_i,
  input  logic                 clr_en_i,
  input  logic [REG_IDX_W-1:0] clr_idx_i,
  output logic [NUM_REGS-1:0]  pending_o
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  assign set_mask  = set_en_i ? idx_mask(set_idx_i) : '0;
  assign clr_mask  = clr_en_i ? idx_mask(clr_idx_i) : '0;
  assign pending_d = (pending_q & ~clr_mask) | set_mask;
  assign pending_o = pending_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/exec_issue_ctrl.sv
// Issue control: decodes one-hot opcodes, stalls on RAW hazards, sequences branch/flush and halt drain.
// Ports: id_* decoded instr in / id_ready+ex_issue out; wb_* retire; ex_br_* branch resolution;
//        flush/pc_load/pc_target redirect; halted; illegal (sticky); stall_cnt when ISSUE_CTRL_STALL_CNT_EN.
// Optional: define ISSUE_CTRL_STALL_CNT_EN to add a saturating 16-bit count of stalled id_valid cycles.
module exec_issue_ctrl
  import exec_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 id_valid,
  input  logic [15:0]          id_opcode,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_dest,
  input  logic                 ex_br_valid,
  input  logic                 ex_br_taken,
  input  logic [31:0]          ex_br_pc,
  output logic                 id_ready,
  output logic                 ex_issue,
  output logic                 flush,
  output logic                 pc_load,
  output logic [31:0]          pc_target,
  output logic                 halted,
  output logic                 illegal
`ifdef ISSUE_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  issue_state_e        state_q, state_d;
  logic [31:0]         pc_target_q;
  logic                illegal_q;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_fwd;
  logic [15:0]         op_eff;
  logic                op_legal;
  logic                hazard;
  logic                issue;

  // Anything that is not exactly one of bits 0..14 executes as NOP.
  assign op_legal = $onehot(id_opcode) && !id_opcode[15];
  assign op_eff   = op_legal ? id_opcode : OP_NOP;

  // A writeback this cycle already frees its register for a dependent instruction.
  assign pending_fwd = pending & ~(wb_valid ? idx_mask(wb_dest) : '0);
  assign hazard      = ((op_eff & OP_NO_SRC_MASK) == '0) &&
                       (pending_fwd[id_rs] || pending_fwd[id_rt]);

  reg_scoreboard u_scoreboard (
    .clock     (clock),
    .reset_n   (reset_n),
    .set_en_i  (issue && ((op_eff & OP_WR_MASK) != '0)),
    .set_idx_i (id_rd),
    .clr_en_i  (wb_valid),
    .clr_idx_i (wb_dest),
    .pending_o (pending)
  );

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      ST_RUN: begin
        issue = id_valid && !hazard;
        if (issue) begin
          if ((op_eff & (OP_BR | OP_BNE)) != '0) begin
            state_d = ST_BR_WAIT;
          end else if (op_eff == OP_HALT) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_BR_WAIT: begin
        if (ex_br_valid) begin
          state_d = ex_br_taken ? ST_FLUSH : ST_RUN;
        end
      end
      ST_FLUSH:  state_d = ST_RUN;
      ST_DRAIN: begin
        // No issues happen here, so only clears can change the scoreboard.
        if (pending_fwd == '0) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      pc_target_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_BR_WAIT && ex_br_valid && ex_br_taken) begin
        pc_target_q <= ex_br_pc;
      end
      if (issue && !op_legal) begin
        illegal_q <= 1'b1;
      end
    end
  end

  assign id_ready  = issue;
  assign ex_issue  = issue;
  assign flush     = (state_q == ST_FLUSH);
  assign pc_load   = (state_q == ST_FLUSH);
  assign pc_target = pc_target_q;
  assign halted    = (state_q == ST_HALTED);
  assign illegal   = illegal_q;

`ifdef ISSUE_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (id_valid && !issue && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/exec_issue_ctrl.md
EXEC_ISSUE_CTRL -- requirements
Module: exec_issue_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clock input, reset_n input.
REQ-002 SHALL have ports: clock in 1 (rising-edge clock); reset_n in 1 (async active-low reset).
REQ-003 SHALL have ports: id_valid in 1 (decoded instr present); id_opcode in 16 (one-hot opcode); id_rs, id_rt, id_rd in 5 each (source and destination registers).
REQ-004 SHALL have ports: wb_valid in 1 (writeback retires a register); wb_dest in 5 (retired register).
REQ-005 SHALL have ports: ex_br_valid in 1 (branch resolved); ex_br_taken in 1; ex_br_pc in 32 (branch target).
REQ-006 SHALL have ports: id_ready out 1 (instr accepted); ex_issue out 1 (load ID_EX); flush out 1; pc_load out 1; pc_target out 32; halted out 1; illegal out 1 (sticky).

Function
REQ-007 SHALL decode the opcode one-hot: bit0 ADD, 1 SUB, 2 LI, 3 SHL, 4 SHR, 5 AND, 6 OR, 7 XOR, 8 BR, 9 BNE, 10 MOVE, 11 ADDI, 12 MUL, 13 HALT, 14 NOP.
REQ-008 SHALL treat a zero opcode, bit15, or more than one set bit as NOP, and SHALL set illegal on issue of such an opcode until reset.
REQ-009 SHALL keep a 32-bit pending scoreboard; issuing a writing op (ADD..XOR excl. BR/BNE, MOVE, ADDI, MUL, LI) SHALL set pending[id_rd].
REQ-010 SHALL clear pending[wb_dest] on wb_valid; same-cycle set and clear of one register SHALL leave it set.
REQ-011 SHALL declare a hazard when id_rs or id_rt is pending, for every op except LI, BR, HALT and NOP; a same-cycle wb_valid to that register SHALL remove the hazard in that cycle.
REQ-012 SHALL use FSM states RUN, BR_WAIT, FLUSH, DRAIN, HALTED.
REQ-013 In RUN: id_ready = ex_issue = id_valid AND NOT hazard, combinationally; in all other states both are 0.
REQ-014 An issue of BR or BNE SHALL move RUN->BR_WAIT; an issue of HALT SHALL move RUN->DRAIN; all other issues stay in RUN.
REQ-015 In BR_WAIT: ex_br_valid with taken SHALL move to FLUSH; ex_br_valid without taken SHALL move to RUN; otherwise the FSM waits indefinitely.
REQ-016 FLUSH SHALL last exactly one cycle with flush=1 and pc_load=1, pc_target = ex_br_pc captured at resolution, then return to RUN.
REQ-017 Latency: taken resolution in cycle N gives flush/pc_load in cycle N+1, and the next issue is possible in cycle N+2.
REQ-018 DRAIN SHALL move to HALTED when the scoreboard is all-zero, including clears made that cycle; HALTED SHALL be terminal until reset, with halted=1.
REQ-019 ex_br_valid outside BR_WAIT SHALL be ignored.

Reset
REQ-020 reset_n low SHALL asynchronously force: state RUN, scoreboard 0, flush 0, pc_load 0, pc_target 0, halted 0, illegal 0, and stall counter 0 when present.
REQ-021 Reset mid-BR_WAIT or mid-DRAIN SHALL discard the pending branch or halt; the first cycle after release behaves as RUN with an empty scoreboard.

Configuration
REQ-022 With ISSUE_CTRL_STALL_CNT_EN defined, the block SHALL add output stall_cnt (16 bits), which increments, saturating at 0xFFFF, each cycle id_valid=1 and id_ready=0.
REQ-023 Without ISSUE_CTRL_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-024 SHALL place the one-hot opcode constants, the FSM state encoding and a register-index width constant (5) in shared package exec_pkg, which the Execution stage also uses.
REQ-025 SHALL implement the scoreboard as sub-module reg_scoreboard with set, clear and pending-vector ports; the FSM stays in exec_issue_ctrl.

Verification
REQ-026 Dependency stall: ADD rd=3 issued; next ADD rs=3 -> id_ready=0 until wb_valid wb_dest=3, issued that same cycle.
REQ-027 Taken branch: BNE issued; 3 cycles later ex_br_valid=1, taken=1, pc=0x40 -> next cycle flush=1, pc_load=1, pc_target=0x40 for 1 cycle; issue resumes the cycle after.
REQ-028 Not-taken branch: BR_WAIT then ex_br_valid=1, taken=0 -> RUN next cycle; flush stays 0.
REQ-029 Halt drain: MUL rd=7 outstanding, HALT issued -> DRAIN; wb_valid dest=7 -> halted=1 next cycle; further id_valid is never accepted.
REQ-030 Illegal/reset: opcode 0x0003 issues as NOP with illegal=1; reset_n pulsed low in BR_WAIT -> all outputs 0, state RUN.
REQ-031 Counter (macro on): 70000 stalled cycles -> stall_cnt=0xFFFF and holds.
